// File: rtl/clock_pkg.sv
// Shared widths, moduli, FSM encoding and edit-field codes for the clock
// time-setting path.
package clock_pkg;

    localparam int HOURS_W   = 5;
    localparam int MIN_W     = 6;
    localparam int SEC_W     = 6;
    localparam int HOURS_MOD = 24;
    localparam int MIN_MOD   = 60;

    localparam logic [2:0] ST_RUN     = 3'd0;
    localparam logic [2:0] ST_SET_HR  = 3'd1;
    localparam logic [2:0] ST_SET_MIN = 3'd2;
    localparam logic [2:0] ST_SET_SEC = 3'd3;
    localparam logic [2:0] ST_COMMIT  = 3'd4;

    localparam logic [1:0] FIELD_NONE    = 2'd0;
    localparam logic [1:0] FIELD_HOURS   = 2'd1;
    localparam logic [1:0] FIELD_MINUTES = 2'd2;
    localparam logic [1:0] FIELD_SECONDS = 2'd3;

    function automatic logic [1:0] field_of_state(input logic [2:0] st);
        case (st)
            ST_SET_HR:  return FIELD_HOURS;
            ST_SET_MIN: return FIELD_MINUTES;
            ST_SET_SEC: return FIELD_SECONDS;
            default:    return FIELD_NONE;
        endcase
    endfunction

    function automatic logic is_set_state(input logic [2:0] st);
        return (st == ST_SET_HR) || (st == ST_SET_MIN) || (st == ST_SET_SEC);
    endfunction

endpackage

// File: rtl/wrap_adjust.sv
// Combinational +/-1 with wrap-around at a modulus; simultaneous inc and dec
// cancel out.
module wrap_adjust #(
    parameter int W   = 6,
    parameter int MOD = 60
) (
    input  logic [W-1:0] value_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] result_o
);

    localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);

    always_comb begin
        result_o = value_i;
        if (inc_i && !dec_i) begin
            result_o = (value_i == MAX_VAL) ? '0 : value_i + W'(1);
        end else if (dec_i && !inc_i) begin
            result_o = (value_i == '0) ? MAX_VAL : value_i - W'(1);
        end
    end

endmodule

// File: rtl/clock_set_controller.sv
// Freezes the time counter, edits a shadow copy field by field from button
// pulses, and parallel-loads the result back into the counter.
module clock_set_controller
    import clock_pkg::*;
#(
    parameter int BLINK_CYCLES = 50_000_000,
    parameter int IDLE_TIMEOUT = 500_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode_btn,
    input  logic               inc_btn,
    input  logic               dec_btn,
    input  logic [HOURS_W-1:0] cur_hours,
    input  logic [MIN_W-1:0]   cur_minutes,
    input  logic [SEC_W-1:0]   cur_seconds,
    output logic               run_en,
    output logic               load,
    output logic [HOURS_W-1:0] load_hours,
    output logic [MIN_W-1:0]   load_minutes,
    output logic [SEC_W-1:0]   load_seconds,
    output logic [1:0]         edit_field,
    output logic               blink
);

    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
    localparam int IDLE_W  = $clog2(IDLE_TIMEOUT + 1);

    logic [2:0]         state_q, state_d;
    logic [HOURS_W-1:0] hr_q, hr_d, hr_adj;
    logic [MIN_W-1:0]   min_q, min_d, min_adj;
    logic [SEC_W-1:0]   sec_q, sec_d, sec_adj;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic               btn_any;
    logic               commit_d;

    wrap_adjust #(.W(HOURS_W), .MOD(HOURS_MOD)) u_adj_hr (
        .value_i(hr_q), .inc_i(inc_btn), .dec_i(dec_btn), .result_o(hr_adj)
    );
    wrap_adjust #(.W(MIN_W), .MOD(MIN_MOD)) u_adj_min (
        .value_i(min_q), .inc_i(inc_btn), .dec_i(dec_btn), .result_o(min_adj)
    );
    wrap_adjust #(.W(SEC_W), .MOD(MIN_MOD)) u_adj_sec (
        .value_i(sec_q), .inc_i(inc_btn), .dec_i(dec_btn), .result_o(sec_adj)
    );

    assign btn_any  = mode_btn | inc_btn | dec_btn;
    assign commit_d = (state_d == ST_COMMIT);

    always_comb begin
        state_d     = state_q;
        hr_d        = hr_q;
        min_d       = min_q;
        sec_d       = sec_q;
        idle_d      = '0;
        blink_d     = 1'b0;
        blink_cnt_d = '0;

        // mode takes priority over inc/dec in every edit state
        case (state_q)
            ST_RUN: begin
                if (mode_btn) begin
                    hr_d    = (cur_hours   < HOURS_W'(HOURS_MOD)) ? cur_hours   : '0;
                    min_d   = (cur_minutes < MIN_W'(MIN_MOD))     ? cur_minutes : '0;
                    sec_d   = (cur_seconds < SEC_W'(MIN_MOD))     ? cur_seconds : '0;
                    state_d = ST_SET_HR;
                end
            end
            ST_SET_HR:  if (mode_btn) state_d = ST_SET_MIN; else hr_d  = hr_adj;
            ST_SET_MIN: if (mode_btn) state_d = ST_SET_SEC; else min_d = min_adj;
            ST_SET_SEC: if (mode_btn) state_d = ST_COMMIT;  else sec_d = sec_adj;
            default:    state_d = ST_RUN;
        endcase

        if (is_set_state(state_q) && !btn_any) begin
            if (idle_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                state_d = ST_RUN;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end

        // a freshly entered field starts visible with a full half-period
        if (is_set_state(state_d)) begin
            if (state_d != state_q) begin
                blink_d = 1'b1;
            end else if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
                blink_d = ~blink_q;
            end else begin
                blink_d     = blink_q;
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            hr_q         <= '0;
            min_q        <= '0;
            sec_q        <= '0;
            idle_q       <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
            run_en       <= 1'b1;
            load         <= 1'b0;
            load_hours   <= '0;
            load_minutes <= '0;
            load_seconds <= '0;
            edit_field   <= FIELD_NONE;
        end else begin
            state_q      <= state_d;
            hr_q         <= hr_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            idle_q       <= idle_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            run_en       <= (state_d == ST_RUN);
            load         <= commit_d;
            load_hours   <= commit_d ? hr_d  : '0;
            load_minutes <= commit_d ? min_d : '0;
            load_seconds <= commit_d ? sec_d : '0;
            edit_field   <= field_of_state(state_d);
        end
    end

    assign blink = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller; committed loads are checked
// against a queue of expected times.
module tb_clock_set_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode_btn, inc_btn, dec_btn;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes, cur_seconds;
    logic       run_en, load, blink;
    logic [4:0] load_hours;
    logic [5:0] load_minutes, load_seconds;
    logic [1:0] edit_field;

    int total = 0;
    int bad   = 0;
    logic [16:0] exp_q[$];

    clock_set_controller #(.BLINK_CYCLES(4), .IDLE_TIMEOUT(20)) dut (
        .clk(clk), .reset(reset),
        .mode_btn(mode_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
        .run_en(run_en), .load(load),
        .load_hours(load_hours), .load_minutes(load_minutes), .load_seconds(load_seconds),
        .edit_field(edit_field), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic m, input logic i, input logic d);
        mode_btn = m; inc_btn = i; dec_btn = d;
        @(posedge clk); #1;
        mode_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cur(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        cur_hours = h; cur_minutes = m; cur_seconds = s;
    endtask

    // every load pulse must match the oldest outstanding expected time
    always @(negedge clk) begin
        if (load === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_load", {15'd0, load_hours, load_minutes, load_seconds}, 32'h1FFFF);
            end else begin
                chk("load_value", {15'd0, load_hours, load_minutes, load_seconds},
                    {15'd0, exp_q.pop_front()});
            end
            chk("load_runen_overlap", {31'd0, run_en}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mode_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
        set_cur(5'd0, 6'd0, 6'd0);
        idle(3);
        reset = 1'b0;
        chk("rst_run_en", {31'd0, run_en}, 32'd1);
        chk("rst_load", {31'd0, load}, 32'd0);
        chk("rst_field", {30'd0, edit_field}, 32'd0);
        chk("rst_blink", {31'd0, blink}, 32'd0);
        chk("rst_load_hours", {27'd0, load_hours}, 32'd0);

        // inc/dec ignored while running
        set_cur(5'd23, 6'd59, 6'd58);
        step(0, 1, 0);
        step(0, 0, 1);
        chk("run_inc_run_en", {31'd0, run_en}, 32'd1);
        chk("run_inc_field", {30'd0, edit_field}, 32'd0);

        // main edit: 23:59:58 -> 00:00:55
        step(1, 0, 0);
        chk("enter_run_en", {31'd0, run_en}, 32'd0);
        chk("enter_field", {30'd0, edit_field}, 32'd1);
        chk("enter_blink", {31'd0, blink}, 32'd1);
        step(0, 1, 0);
        step(1, 0, 0);
        chk("min_field", {30'd0, edit_field}, 32'd2);
        step(0, 1, 0);
        step(1, 0, 0);
        chk("sec_field", {30'd0, edit_field}, 32'd3);
        chk("sec_run_en", {31'd0, run_en}, 32'd0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        exp_q.push_back({5'd0, 6'd0, 6'd55});
        step(1, 0, 0);
        chk("commit_load", {31'd0, load}, 32'd1);
        chk("commit_run_en", {31'd0, run_en}, 32'd0);
        chk("commit_field", {30'd0, edit_field}, 32'd0);
        chk("commit_blink", {31'd0, blink}, 32'd0);
        idle(1);
        chk("after_commit_run_en", {31'd0, run_en}, 32'd1);
        chk("after_commit_load", {31'd0, load}, 32'd0);

        // wrap boundaries, inc+dec cancel, mode beats inc
        set_cur(5'd0, 6'd59, 6'd30);
        step(1, 0, 0);
        step(0, 0, 1);
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 1, 1);
        step(1, 1, 0);
        chk("mode_inc_field", {30'd0, edit_field}, 32'd3);
        step(0, 1, 1);
        exp_q.push_back({5'd23, 6'd0, 6'd30});
        step(1, 0, 0);
        idle(1);

        // out-of-range capture becomes zero
        set_cur(5'd31, 6'd63, 6'd60);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        exp_q.push_back({5'd0, 6'd0, 6'd0});
        step(1, 0, 0);
        idle(1);

        // idle timeout after 20 quiet cycles
        set_cur(5'd10, 6'd20, 6'd30);
        step(1, 0, 0);
        idle(19);
        chk("pre_timeout_field", {30'd0, edit_field}, 32'd1);
        chk("pre_timeout_run_en", {31'd0, run_en}, 32'd0);
        idle(1);
        chk("timeout_run_en", {31'd0, run_en}, 32'd1);
        chk("timeout_field", {30'd0, edit_field}, 32'd0);
        chk("timeout_blink", {31'd0, blink}, 32'd0);

        // a press at cycle 19 restarts the idle count
        step(1, 0, 0);
        idle(18);
        step(0, 1, 0);
        idle(1);
        chk("press19_field", {30'd0, edit_field}, 32'd1);
        chk("press19_run_en", {31'd0, run_en}, 32'd0);
        step(1, 0, 0);
        step(1, 0, 0);
        exp_q.push_back({5'd11, 6'd20, 6'd30});
        step(1, 0, 0);
        idle(1);

        // blink cadence in SET_MIN
        set_cur(5'd1, 6'd2, 6'd3);
        step(1, 0, 0);
        idle(1);
        step(1, 0, 0);
        chk("blink_entry_min", {31'd0, blink}, 32'd1);
        for (int k = 1; k <= 12; k++) begin
            idle(1);
            chk($sformatf("blink_k%0d", k), {31'd0, blink}, ((k / 4) % 2 == 0) ? 32'd1 : 32'd0);
        end
        step(1, 0, 0);
        chk("blink_entry_sec", {31'd0, blink}, 32'd1);
        exp_q.push_back({5'd1, 6'd2, 6'd3});
        step(1, 0, 0);
        chk("blink_commit", {31'd0, blink}, 32'd0);
        idle(1);
        chk("blink_run", {31'd0, blink}, 32'd0);

        // reset while editing seconds
        set_cur(5'd5, 6'd6, 6'd7);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("rst_sec_run_en", {31'd0, run_en}, 32'd1);
        chk("rst_sec_field", {30'd0, edit_field}, 32'd0);
        chk("rst_sec_load", {31'd0, load}, 32'd0);

        // reset on the edge that would enter COMMIT
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        reset = 1'b1;
        step(1, 0, 0);
        reset = 1'b0;
        chk("rst_commit_edge_load", {31'd0, load}, 32'd0);
        chk("rst_commit_edge_run_en", {31'd0, run_en}, 32'd1);
        chk("rst_commit_edge_hours", {27'd0, load_hours}, 32'd0);

        // reset while COMMIT is active
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        exp_q.push_back({5'd5, 6'd6, 6'd7});
        step(1, 0, 0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("rst_in_commit_load", {31'd0, load}, 32'd0);
        chk("rst_in_commit_minutes", {26'd0, load_minutes}, 32'd0);
        chk("rst_in_commit_run_en", {31'd0, run_en}, 32'd1);

        idle(2);
        chk("pending_loads", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_set_controller.md
# clock_set_controller

Time-setting controller for the 24-hour digital clock counter. Sequences the counter between free-running and user edit: freezes it, lets the user adjust hours, minutes and seconds in a shadow copy via single-cycle button pulses, then loads the edited time back in one cycle. Sits between the debounced button front end and the hours/minutes/seconds counter, driving that counter's enable and parallel-load inputs.

## Interface
- BLINK_CYCLES, 50_000_000: clk cycles per half-period of the edit-field blink.
- IDLE_TIMEOUT, 500_000_000: clk cycles without any button pulse in an edit state before the edit is abandoned.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mode_btn  in  1  single-cycle pulse, already debounced; advances the edit field.
- inc_btn  in  1  single-cycle pulse; increments the field being edited.
- dec_btn  in  1  single-cycle pulse; decrements the field being edited.
- cur_hours  in  5  live hours from the counter, 0–23.
- cur_minutes  in  6  live minutes, 0–59.
- cur_seconds  in  6  live seconds, 0–59.
- run_en  out  1  counter count enable; 1 only in RUN.
- load  out  1  one-cycle parallel-load strobe to the counter.
- load_hours  out  5  value to load; valid when load=1.
- load_minutes  out  6  value to load; valid when load=1.
- load_seconds  out  6  value to load; valid when load=1.
- edit_field  out  2  0=none, 1=hours, 2=minutes, 3=seconds.
- blink  out  1  display blank toggle for the field being edited.

## Operation
- The only clock is clk; reset is synchronous and active-high.
- States: RUN, SET_HR, SET_MIN, SET_SEC, COMMIT.
- All outputs are registered and decoded from the state and shadow registers.
- Reset values: state RUN, run_en=1, load=0, load_* = 0, edit_field=0, blink=0, shadow registers 0, timers 0.
- RUN: inc_btn and dec_btn are ignored. On mode_btn, capture the cur_* values into the shadow registers and go to SET_HR. A captured value out of range (hours >23, minutes or seconds >59) is replaced by 0.
- SET_HR:
  - inc_btn: hours+1, with 23 wrapping to 0.
  - dec_btn: hours-1, with 0 wrapping to 23.
  - mode_btn: go to SET_MIN.
- SET_MIN and SET_SEC: same as SET_HR with modulus 60 (59↔0). mode_btn goes SET_MIN→SET_SEC and SET_SEC→COMMIT.
- COMMIT: lasts exactly one cycle. load=1 and load_* hold the shadow values. Next state is RUN.
- Simultaneous events:
  - inc_btn and dec_btn in the same cycle: no change.
  - mode_btn together with inc_btn or dec_btn: mode wins and the adjustment is discarded.
- Idle timeout: in any SET state, after IDLE_TIMEOUT consecutive cycles with no button pulse, return to RUN. No load is issued and the shadow values are discarded. Any button pulse clears the idle timer.
- blink:
  - Toggles every BLINK_CYCLES cycles while in a SET state.
  - Forced to 0 in RUN and COMMIT.
  - The blink counter clears and blink is set to 1 on entry to each SET state, so the new field shows visible immediately.
- Reset mid-edit, including during COMMIT: go to RUN with no load pulse. If reset coincides with COMMIT, load stays 0.

## Timing
- mode_btn sampled at edge N in RUN: run_en=0 and edit_field=1 from edge N+1.
- inc_btn or dec_btn at edge N: the updated shadow value is visible internally from edge N+1.
- mode_btn at edge N in SET_SEC: load=1 for the single cycle N+1..N+2. run_en=1 from edge N+2. The counter therefore first counts from the loaded value one cycle after the load.
- load never overlaps run_en=1.
- edit_field follows the state with the same one-cycle latency.
- Timeout fires on the edge where the idle count reaches IDLE_TIMEOUT. run_en=1 from that edge.

## Structure
- Shared package clock_pkg holds:
  - HOURS_W=5, MIN_W=6, SEC_W=6
  - HOURS_MOD=24, MIN_MOD=60
  - the state encoding (RUN, SET_HR, SET_MIN, SET_SEC, COMMIT)
  - the edit_field codes
- One natural sub-module, wrap_adjust: a combinational ±1 with wrap. It takes value, inc, dec and a modulus parameter, and is instantiated once per field.
- FSM, shadow registers, blink counter and idle timer live in clock_set_controller.

## Test plan
- Reset with BLINK_CYCLES=4 and IDLE_TIMEOUT=20 → run_en=1, load=0, edit_field=0, blink=0. inc_btn pulses in RUN → no load, outputs unchanged.
- cur=23:59:58. Pulse sequence mode, inc (hours), mode, inc (minutes), mode, dec, dec, dec (seconds), mode → one load cycle with 00:00:55. run_en=0 from the first mode until the cycle after load.
- In SET_HR: dec from 0 → 23. In SET_MIN: inc from 59 → 0. inc_btn and dec_btn together → value unchanged. mode_btn together with inc_btn → field advances, value unchanged.
- Enter SET_HR, then no buttons for 20 cycles → back to RUN, load never asserted, run_en=1 on the timeout edge. Repeat with a press at cycle 19 → still in edit.
- In SET_MIN, blink → 1 on entry, then toggles every 4 cycles. Forced to 0 in RUN.
- reset asserted in SET_SEC, and separately on the COMMIT cycle → state RUN, load=0, load_*=0, run_en=1 next cycle.
